// File: rtl/csm_pkg.sv
// Shared types for the dual-processor memory arbiter: FSM states, error codes,
// port identifiers and the lock-table entry layout.
package csm_pkg;

    localparam int CSM_AD_W         = 8;
    localparam int CSM_LOCK_ENTRIES = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        WREQ  = 3'd2,
        WDATA = 3'd3,
        WRITE = 3'd4,
        RDATA = 3'd5,
        RWAIT = 3'd6,
        RESP  = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK     = 2'b00,
        ERR_LOCKED = 2'b01,
        ERR_NOLOCK = 2'b10,
        ERR_FULL   = 2'b11
    } err_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    typedef struct packed {
        logic                valid;
        port_t               owner;
        logic [CSM_AD_W-1:0] addr;
    } lock_entry_t;

    function automatic port_t other_port(input port_t p);
        return (p == PORT_A) ? PORT_B : PORT_A;
    endfunction

endpackage

// File: rtl/csm_lock_table.sv
// Small CAM of held addresses. Lookup is combinational on the latched request;
// alloc/free strobes commit at the end of the CHECK cycle.
module csm_lock_table
    import csm_pkg::*;
#(
    parameter  int ENTRIES = CSM_LOCK_ENTRIES,
    localparam int IW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CSM_AD_W-1:0] addr_i,
    input  port_t               port_i,
    input  logic                alloc_i,
    input  logic                free_i,
    output logic                hit_self_o,
    output logic                hit_other_o,
    output logic                free_avail_o,
    output logic [IW-1:0]       free_idx_o
);

    lock_entry_t [ENTRIES-1:0] tbl_q, tbl_d;
    logic [ENTRIES-1:0]        self_vec, other_vec, free_vec;

    always_comb begin
        self_vec  = '0;
        other_vec = '0;
        free_vec  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            free_vec[i] = !tbl_q[i].valid;
            if (tbl_q[i].valid && (tbl_q[i].addr == addr_i)) begin
                self_vec[i]  = (tbl_q[i].owner == port_i);
                other_vec[i] = (tbl_q[i].owner != port_i);
            end
        end
    end

    // Descending scan so the lowest free slot is the one that sticks.
    always_comb begin
        free_idx_o = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (free_vec[i]) free_idx_o = i[IW-1:0];
        end
    end

    assign hit_self_o   = |self_vec;
    assign hit_other_o  = |other_vec;
    assign free_avail_o = |free_vec;

    always_comb begin
        tbl_d = tbl_q;
        if (free_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (self_vec[i]) tbl_d[i].valid = 1'b0;
            end
        end
        if (alloc_i && free_avail_o) begin
            tbl_d[free_idx_o].valid = 1'b1;
            tbl_d[free_idx_o].owner = port_i;
            tbl_d[free_idx_o].addr  = addr_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tbl_q <= '0;
        else          tbl_q <= tbl_d;
    end

endmodule

// File: rtl/csm_arbiter.sv
// Round-robin arbiter sequencing port A/B read, write, hold and release requests
// onto a shared single-port memory. Every output is a flop fed from next-state decode.
module csm_arbiter
    import csm_pkg::*;
#(
    parameter int AD_W         = CSM_AD_W,
    parameter int LOCK_ENTRIES = CSM_LOCK_ENTRIES
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [AD_W-1:0] A_in_AD,
    input  logic            A_enable,
    input  logic            A_rw,
    input  logic            A_hold,
    input  logic            A_release,
    output logic            A_ack,
    output logic [1:0]      A_err,
    output logic [AD_W-1:0] A_out_data,
    input  logic [AD_W-1:0] B_in_AD,
    input  logic            B_enable,
    input  logic            B_rw,
    input  logic            B_hold,
    input  logic            B_release,
    output logic            B_ack,
    output logic [1:0]      B_err,
    output logic [AD_W-1:0] B_out_data,
    output logic [AD_W-1:0] mem_addr,
    output logic [AD_W-1:0] mem_wdata,
    output logic            mem_we,
    output logic            mem_re,
    input  logic [AD_W-1:0] mem_rdata
);

    localparam int IW = (LOCK_ENTRIES > 1) ? $clog2(LOCK_ENTRIES) : 1;

    state_t          state_q, state_d;
    port_t           port_q, port_d, last_q, last_d, win;
    logic [AD_W-1:0] addr_q, addr_d;
    logic            rw_q, rw_d, hold_q, hold_d, rel_q, rel_d;

    logic            a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic [1:0]      a_err_q, a_err_d, b_err_q, b_err_d;
    logic [AD_W-1:0] a_out_q, a_out_d, b_out_q, b_out_d;
    logic [AD_W-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic            mem_we_q, mem_we_d, mem_re_q, mem_re_d;

    err_t            chk_err;
    logic            lk_alloc, lk_free;
    logic            hit_self, hit_other, free_avail;
    logic [IW-1:0]   free_idx;
    logic [AD_W-1:0] cur_ad;

    csm_lock_table #(.ENTRIES(LOCK_ENTRIES)) u_locks (
        .clk          (clk),
        .reset_n      (reset_n),
        .addr_i       (addr_q),
        .port_i       (port_q),
        .alloc_i      (lk_alloc),
        .free_i       (lk_free),
        .hit_self_o   (hit_self),
        .hit_other_o  (hit_other),
        .free_avail_o (free_avail),
        .free_idx_o   (free_idx)
    );

    assign cur_ad = (port_q == PORT_A) ? A_in_AD : B_in_AD;

    always_comb begin
        state_d  = state_q;
        port_d   = port_q;
        last_d   = last_q;
        addr_d   = addr_q;
        rw_d     = rw_q;
        hold_d   = hold_q;
        rel_d    = rel_q;
        win      = PORT_A;
        chk_err  = ERR_OK;
        lk_alloc = 1'b0;
        lk_free  = 1'b0;
        case (state_q)
            IDLE: begin
                if (A_enable || B_enable) begin
                    if (A_enable && B_enable) win = other_port(last_q);
                    else                      win = A_enable ? PORT_A : PORT_B;
                    port_d  = win;
                    last_d  = win;
                    addr_d  = (win == PORT_A) ? A_in_AD   : B_in_AD;
                    rw_d    = (win == PORT_A) ? A_rw      : B_rw;
                    hold_d  = (win == PORT_A) ? A_hold    : B_hold;
                    rel_d   = (win == PORT_A) ? A_release : B_release;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                // Release outranks everything, including hold and a foreign lock.
                if (rel_q) begin
                    state_d = RESP;
                    if (hit_self) lk_free = 1'b1;
                    else          chk_err = ERR_NOLOCK;
                end else if (hit_other) begin
                    state_d = RESP;
                    chk_err = ERR_LOCKED;
                end else if (hold_q && !hit_self && !free_avail) begin
                    state_d = RESP;
                    chk_err = ERR_FULL;
                end else begin
                    lk_alloc = hold_q && !hit_self;
                    state_d  = rw_q ? WREQ : RDATA;
                end
            end
            WREQ:    state_d = WDATA;
            WDATA:   state_d = WRITE;
            WRITE:   state_d = IDLE;
            RDATA:   state_d = RWAIT;
            RWAIT:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the state being entered, so they appear with it.
    always_comb begin
        a_ack_d     = (state_d == WREQ || state_d == RESP) && (port_d == PORT_A);
        b_ack_d     = (state_d == WREQ || state_d == RESP) && (port_d == PORT_B);
        a_err_d     = (a_ack_d && state_q == CHECK) ? chk_err : ERR_OK;
        b_err_d     = (b_ack_d && state_q == CHECK) ? chk_err : ERR_OK;
        mem_re_d    = (state_d == RDATA);
        mem_we_d    = (state_d == WRITE);
        mem_addr_d  = (mem_re_d || mem_we_d) ? addr_q : '0;
        mem_wdata_d = mem_we_d ? cur_ad : '0;
        a_out_d     = a_out_q;
        b_out_d     = b_out_q;
        if (state_q == RWAIT) begin
            if (port_q == PORT_A) a_out_d = mem_rdata;
            else                  b_out_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            port_q      <= PORT_A;
            last_q      <= PORT_B;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            hold_q      <= 1'b0;
            rel_q       <= 1'b0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            a_err_q     <= '0;
            b_err_q     <= '0;
            a_out_q     <= '0;
            b_out_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            last_q      <= last_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            hold_q      <= hold_d;
            rel_q       <= rel_d;
            a_ack_q     <= a_ack_d;
            b_ack_q     <= b_ack_d;
            a_err_q     <= a_err_d;
            b_err_q     <= b_err_d;
            a_out_q     <= a_out_d;
            b_out_q     <= b_out_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
        end
    end

    assign A_ack      = a_ack_q;
    assign A_err      = a_err_q;
    assign A_out_data = a_out_q;
    assign B_ack      = b_ack_q;
    assign B_err      = b_err_q;
    assign B_out_data = b_out_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
    assign mem_re     = mem_re_q;

endmodule
